pin_entry_controller: RTL and testbench

- Sequences the matrix keypad decoder output into a complete PIN and hands it to the door-lock FSM.
- Consumes the decoder's level-held tecla_valid/tecla_value pair and converts each press into one key event.
- Digits accumulate in a BCD buffer; '*' clears the entry, '#' confirms it.
- A confirmed code is presented on a valid/ready handshake. An inactivity timeout discards a stale partial entry.

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/inactivity_timer.sv | 40 ++++
 rtl/pin_entry_controller.sv | 137 +++++++++++++
 tb/tb_pin_entry_controller.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared key codes, PIN-entry state encoding and key helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam logic [3:0] KEY_STAR  = 4'd15;
  localparam logic [3:0] KEY_HASH  = 4'd13;
  localparam logic [3:0] KEY_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    PRESENT = 2'd2
  } pin_state_t;

  // Decimal digit keys are 0-9; everything above is a command or letter key.
  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/inactivity_timer.sv
`default_nettype none
// ============================================================================
// Module      : inactivity_timer
// Description : Counts cycles while running; flags the last cycle of the
//               inactivity window so the owner can discard stale entries.
// Revision    : 1.0 - initial release
// ============================================================================
module inactivity_timer #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int                 c_width = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_width-1:0] c_last  = c_width'(TIMEOUT_CYCLES - 1);

  logic [c_width-1:0] r_count;
  logic               w_at_last;

  assign w_at_last = (r_count == c_last);
  // The owner leaves ENTRY (or clears) on this cycle, so the flag lasts one cycle.
  assign expire    = run && w_at_last;

  // Free-running count while enabled; parks at the last value instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (run && !w_at_last) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pin_entry_controller.sv
`default_nettype none
// ============================================================================
// Module      : pin_entry_controller
// Description : Turns keypad decoder presses into a BCD PIN, confirms it with
//               '#', clears with '*', and offers it on a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module pin_entry_controller
  import keypad_pkg::*;
#(
  parameter int MAX_DIGITS     = 8,
  parameter int MIN_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [3:0]                         tecla_value,
  input  logic                               tecla_valid,
  input  logic                               enable,
  output logic [4*MAX_DIGITS-1:0]            code_out,
  output logic [$clog2(MAX_DIGITS+1)-1:0]    digit_count,
  output logic                               code_valid,
  input  logic                               code_ready,
  output logic                               entry_active,
  output logic                               err_pulse,
  output logic                               timeout_pulse
);

  localparam int                      c_cnt_w = $clog2(MAX_DIGITS + 1);
  localparam logic [c_cnt_w-1:0]      c_max   = c_cnt_w'(MAX_DIGITS);
  localparam logic [c_cnt_w-1:0]      c_min   = c_cnt_w'(MIN_DIGITS);
  localparam logic [4*MAX_DIGITS-1:0] c_blank = {MAX_DIGITS{KEY_BLANK}};

  pin_state_t r_state;
  logic       r_tecla_valid_q;
  logic       w_key_event;
  logic       w_is_digit;
  logic       w_room;
  logic       w_timer_clear;
  logic       w_timer_run;
  logic       w_expire;

  // The decoder holds tecla_valid for the whole press, so only its rising edge is an event.
  assign w_key_event   = enable && tecla_valid && !r_tecla_valid_q;
  assign w_is_digit    = is_digit(tecla_value);
  assign w_room        = (digit_count < c_max);
  // Any digit that actually lands in the buffer restarts the inactivity window.
  assign w_timer_clear = w_key_event && w_is_digit &&
                         ((r_state == IDLE) || ((r_state == ENTRY) && w_room));
  assign w_timer_run   = (r_state == ENTRY);

  inactivity_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (w_timer_clear),
    .run   (w_timer_run),
    .expire(w_expire)
  );

  // Edge-detect history; tracked regardless of enable so a press held across enable never fires.
  always_ff @(posedge clk) begin
    if (reset) r_tecla_valid_q <= 1'b0;
    else       r_tecla_valid_q <= tecla_valid;
  end

  // Entry state machine; key events take priority over the timeout on the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      code_out      <= c_blank;
      digit_count   <= '0;
      code_valid    <= 1'b0;
      entry_active  <= 1'b0;
      err_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      err_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_key_event && w_is_digit) begin
            code_out     <= {c_blank[4*MAX_DIGITS-1:4], tecla_value};
            digit_count  <= c_cnt_w'(1);
            entry_active <= 1'b1;
            r_state      <= ENTRY;
          end
        end
        ENTRY: begin
          if (w_key_event && w_is_digit && w_room) begin
            code_out    <= {code_out[4*MAX_DIGITS-5:0], tecla_value};
            digit_count <= digit_count + 1'b1;
          end else if (w_key_event && (tecla_value == KEY_HASH)) begin
            entry_active <= 1'b0;
            if (digit_count >= c_min) begin
              code_valid <= 1'b1;
              r_state    <= PRESENT;
            end else begin
              code_out    <= c_blank;
              digit_count <= '0;
              err_pulse   <= 1'b1;
              r_state     <= IDLE;
            end
          end else if (w_key_event && (tecla_value == KEY_STAR)) begin
            code_out     <= c_blank;
            digit_count  <= '0;
            entry_active <= 1'b0;
            r_state      <= IDLE;
          end else if (w_expire) begin
            code_out      <= c_blank;
            digit_count   <= '0;
            entry_active  <= 1'b0;
            timeout_pulse <= 1'b1;
            r_state       <= IDLE;
          end else if (w_key_event && w_is_digit) begin
            // Buffer full: keep the code, flag the rejected digit.
            err_pulse <= 1'b1;
          end
        end
        PRESENT: begin
          if (code_ready) begin
            code_valid  <= 1'b0;
            code_out    <= c_blank;
            digit_count <= '0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pin_entry_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pin_entry_controller
// Description : Self-checking bench for pin_entry_controller (vector table,
//               expectation queue, and hand-written timing corner cases).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pin_entry_controller;
  import keypad_pkg::*;

  localparam int MAXD = 8;
  localparam int MIND = 4;
  localparam int TOUT = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  tecla_value;
  logic        tecla_valid;
  logic        enable;
  logic [31:0] code_out;
  logic [3:0]  digit_count;
  logic        code_valid;
  logic        code_ready;
  logic        entry_active;
  logic        err_pulse;
  logic        timeout_pulse;

  pin_entry_controller #(
    .MAX_DIGITS(MAXD),
    .MIN_DIGITS(MIND),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tecla_value(tecla_value),
    .tecla_valid(tecla_valid),
    .enable(enable),
    .code_out(code_out),
    .digit_count(digit_count),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .entry_active(entry_active),
    .err_pulse(err_pulse),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  key;
    int          hold;
    int          gap;
    logic [31:0] code;
    int          cnt;
    logic        valid;
    int          errs;
    int          touts;
  } vec_t;

  typedef struct {
    logic [31:0] code;
    int          cnt;
    logic        valid;
    int          errs;
    int          touts;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  int   n_tests    = 0;
  int   n_fail     = 0;
  int   err_cnt    = 0;
  int   tout_cnt   = 0;
  int   valid_seen = 0;
  int   width_viol = 0;
  logic prev_err   = 1'b0;
  logic prev_tout  = 1'b0;

  // Pulse accounting away from the active edge.
  always @(negedge clk) begin
    if (err_pulse)     err_cnt++;
    if (timeout_pulse) tout_cnt++;
    if (code_valid)    valid_seen++;
    if ((err_pulse && prev_err) || (timeout_pulse && prev_tout) || (err_pulse && timeout_pulse))
      width_viol++;
    prev_err  = err_pulse;
    prev_tout = timeout_pulse;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] key, input int hold, input int gap);
    tecla_value = key;
    tecla_valid = 1'b1;
    repeat (hold) tick();
    tecla_valid = 1'b0;
    repeat (gap) tick();
  endtask

  function automatic vec_t mk(input logic [3:0] key, input int hold, input int gap,
                              input logic [31:0] code, input int cnt, input logic valid,
                              input int errs, input int touts);
    vec_t v;
    v.key = key; v.hold = hold; v.gap = gap; v.code = code;
    v.cnt = cnt; v.valid = valid; v.errs = errs; v.touts = touts;
    return v;
  endfunction

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      exp_t e;
      e.code  = vecs[i].code;
      e.cnt   = vecs[i].cnt;
      e.valid = vecs[i].valid;
      e.errs  = vecs[i].errs;
      e.touts = vecs[i].touts;
      exp_q.push_back(e);
      err_cnt  = 0;
      tout_cnt = 0;
      press(vecs[i].key, vecs[i].hold, vecs[i].gap);
      e = exp_q.pop_front();
      check($sformatf("vec%0d_code", i),  code_out,            e.code);
      check($sformatf("vec%0d_count", i), 32'(digit_count),    e.cnt);
      check($sformatf("vec%0d_valid", i), 32'(code_valid),     32'(e.valid));
      check($sformatf("vec%0d_err", i),   err_cnt,             e.errs);
      check($sformatf("vec%0d_tout", i),  tout_cnt,            e.touts);
    end
  endtask

  initial begin
    int first_to;
    int max_cnt;

    // 0-4: normal 4-digit entry and confirm
    vecs.push_back(mk(4'd1,    10, 5, 32'hFFFFFFF1, 1, 1'b0, 0, 0));
    vecs.push_back(mk(4'd2,    10, 5, 32'hFFFFFF12, 2, 1'b0, 0, 0));
    vecs.push_back(mk(4'd3,    10, 5, 32'hFFFFF123, 3, 1'b0, 0, 0));
    vecs.push_back(mk(4'd4,    10, 5, 32'hFFFF1234, 4, 1'b0, 0, 0));
    vecs.push_back(mk(KEY_HASH,10, 5, 32'hFFFF1234, 4, 1'b1, 0, 0));
    // 5-7: too-short confirm
    vecs.push_back(mk(4'd5,    10, 5, 32'hFFFFFFF5, 1, 1'b0, 0, 0));
    vecs.push_back(mk(4'd6,    10, 5, 32'hFFFFFF56, 2, 1'b0, 0, 0));
    vecs.push_back(mk(KEY_HASH,10, 5, 32'hFFFFFFFF, 0, 1'b0, 1, 0));
    // 8-10: command and letter keys in IDLE are ignored
    vecs.push_back(mk(KEY_STAR, 3, 2, 32'hFFFFFFFF, 0, 1'b0, 0, 0));
    vecs.push_back(mk(KEY_HASH, 3, 2, 32'hFFFFFFFF, 0, 1'b0, 0, 0));
    vecs.push_back(mk(4'd10,    3, 2, 32'hFFFFFFFF, 0, 1'b0, 0, 0));
    // 11-21: overflow past MAX_DIGITS, letter key mid-entry, then '*'
    vecs.push_back(mk(4'd1,  3, 2, 32'hFFFFFFF1, 1, 1'b0, 0, 0));
    vecs.push_back(mk(4'd2,  3, 2, 32'hFFFFFF12, 2, 1'b0, 0, 0));
    vecs.push_back(mk(4'd3,  3, 2, 32'hFFFFF123, 3, 1'b0, 0, 0));
    vecs.push_back(mk(4'd11, 3, 2, 32'hFFFFF123, 3, 1'b0, 0, 0));
    vecs.push_back(mk(4'd4,  3, 2, 32'hFFFF1234, 4, 1'b0, 0, 0));
    vecs.push_back(mk(4'd5,  3, 2, 32'hFFF12345, 5, 1'b0, 0, 0));
    vecs.push_back(mk(4'd6,  3, 2, 32'hFF123456, 6, 1'b0, 0, 0));
    vecs.push_back(mk(4'd7,  3, 2, 32'hF1234567, 7, 1'b0, 0, 0));
    vecs.push_back(mk(4'd8,  3, 2, 32'h12345678, 8, 1'b0, 0, 0));
    vecs.push_back(mk(4'd9,  3, 2, 32'h12345678, 8, 1'b0, 1, 0));
    vecs.push_back(mk(KEY_STAR, 3, 2, 32'hFFFFFFFF, 0, 1'b0, 0, 0));

    reset = 1'b1; tecla_value = 4'd0; tecla_valid = 1'b0; enable = 1'b1; code_ready = 1'b0;
    repeat (3) tick();
    check("rst_code",  code_out,              32'hFFFFFFFF);
    check("rst_count", 32'(digit_count),      32'd0);
    check("rst_valid", 32'(code_valid),       32'd0);
    check("rst_entry", 32'(entry_active),     32'd0);
    check("rst_err",   32'(err_pulse),        32'd0);
    check("rst_tout",  32'(timeout_pulse),    32'd0);
    reset = 1'b0;
    tick();

    run_vecs(0, 5);
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    check("ready_valid", 32'(code_valid),  32'd0);
    check("ready_code",  code_out,         32'hFFFFFFFF);
    check("ready_count", 32'(digit_count), 32'd0);
    tick();

    valid_seen = 0;
    run_vecs(5, 8);
    check("short_never_valid", valid_seen, 32'd0);
    check("short_entry", 32'(entry_active), 32'd0);

    run_vecs(8, 22);

    // Held key: one event; the idle entry then times out TOUT edges after the digit edge.
    err_cnt = 0; tout_cnt = 0; first_to = -1; max_cnt = 0;
    tecla_value = 4'd7; tecla_valid = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k == 1) begin
        check("hold7_count", 32'(digit_count),   32'd1);
        check("hold7_digit", 32'(code_out[3:0]), 32'd7);
        check("hold7_entry", 32'(entry_active),  32'd1);
      end
      if (timeout_pulse && first_to < 0) first_to = k;
      if (int'(digit_count) > max_cnt) max_cnt = int'(digit_count);
    end
    tecla_valid = 1'b0;
    repeat (5) tick();
    check("hold7_max_count", max_cnt,  32'd1);
    check("hold7_to_edge",   first_to, 32'd21);
    check("hold7_to_count",  tout_cnt, 32'd1);
    check("hold7_err",       err_cnt,  32'd0);
    check("hold7_code",      code_out, 32'hFFFFFFFF);

    // Letter key mid-entry does not restart the window.
    tout_cnt = 0; first_to = -1;
    tecla_value = 4'd3; tecla_valid = 1'b1; tick();
    tecla_valid = 1'b0; repeat (9) tick();
    tecla_value = 4'd12; tecla_valid = 1'b1; tick();
    tecla_valid = 1'b0;
    for (int k = 11; k <= 25; k++) begin
      tick();
      if (timeout_pulse && first_to < 0) first_to = k;
    end
    check("letter_to_edge",  first_to, 32'd20);
    check("letter_to_count", tout_cnt, 32'd1);

    // Digit arriving exactly on the expiry cycle wins over the timeout.
    err_cnt = 0; tout_cnt = 0;
    tecla_value = 4'd3; tecla_valid = 1'b1; tick();
    tecla_valid = 1'b0; repeat (19) tick();
    tecla_value = 4'd5; tecla_valid = 1'b1; tick();
    tecla_valid = 1'b0; tick();
    check("expiry_digit_count", 32'(digit_count), 32'd2);
    check("expiry_digit_code",  code_out,         32'hFFFFFF35);
    check("expiry_digit_tout",  tout_cnt,         32'd0);
    press(KEY_STAR, 3, 2);
    check("expiry_star_count", 32'(digit_count), 32'd0);
    check("expiry_star_tout",  tout_cnt,         32'd0);

    // PRESENT ignores keys and never times out; reset clears it without pulses.
    press(4'd4, 3, 2); press(4'd3, 3, 2); press(4'd2, 3, 2); press(4'd1, 3, 2);
    press(KEY_HASH, 3, 2);
    check("present_valid", 32'(code_valid), 32'd1);
    err_cnt = 0; tout_cnt = 0;
    press(4'd8, 10, 25);
    check("present_hold_valid", 32'(code_valid),  32'd1);
    check("present_hold_code",  code_out,         32'hFFFF4321);
    check("present_hold_count", 32'(digit_count), 32'd4);
    check("present_hold_tout",  tout_cnt,         32'd0);
    check("present_hold_err",   err_cnt,          32'd0);
    reset = 1'b1;
    tick();
    check("midrst_valid", 32'(code_valid),    32'd0);
    check("midrst_code",  code_out,           32'hFFFFFFFF);
    check("midrst_count", 32'(digit_count),   32'd0);
    check("midrst_err",   32'(err_pulse),     32'd0);
    check("midrst_tout",  32'(timeout_pulse), 32'd0);
    reset = 1'b0;
    tick();

    // Disabled press is ignored, and a press held across enable rising stays ignored.
    enable = 1'b0;
    press(4'd4, 10, 5);
    check("dis_count", 32'(digit_count),  32'd0);
    check("dis_entry", 32'(entry_active), 32'd0);
    tecla_value = 4'd6; tecla_valid = 1'b1; tick();
    enable = 1'b1;
    repeat (5) tick();
    tecla_valid = 1'b0; tick();
    check("dis_held_count", 32'(digit_count), 32'd0);
    check("dis_held_code",  code_out,         32'hFFFFFFFF);

    check("pulse_shape", width_viol, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
